// File: rtl/key_event_decoder.sv
// key_event_decoder: turns the debounced key level/edge strobe into one-cycle
// gesture events (short press, double click, long press, auto-repeat).
// All outputs are registered; at most one event output is high per cycle.
module key_event_decoder #(
   parameter int unsigned LONG_CYCLES   = 50_000_000,
   parameter int unsigned DCLICK_GAP    = 15_000_000,
   parameter int unsigned REPEAT_CYCLES = 10_000_000,
   parameter bit          DCLICK_EN     = 1'b1,
   parameter int unsigned CNT_W         = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic key_state,
   input  logic key_flag,
   output logic short_press,
   output logic double_click,
   output logic long_press,
   output logic repeat_tick,
   output logic busy
);

   typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

   // A threshold of N fires while the timer holds N-1.
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DCLICK_GAP - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q;
   logic             press_edge, release_edge, thr_hit, timer_clr;
   logic             ev_short, ev_dclick, ev_long, ev_repeat;

   assign press_edge   = key_flag & ~key_state;
   assign release_edge = key_flag &  key_state;

   // Threshold compare for whichever timed state is active.
   always_comb begin
      thr_hit = 1'b0;
      unique case (state_q)
         PRESS1, PRESS2: thr_hit = (timer_q == LONG_LAST);
         WAIT2:          thr_hit = (timer_q == GAP_LAST);
         LONG:           thr_hit = (timer_q == REP_LAST);
         default:        thr_hit = 1'b0;
      endcase
   end

   // State and timer register; timer restarts on every transition and on each repeat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         if (timer_clr)
            timer_q <= '0;
         else if (state_q != IDLE)
            timer_q <= timer_q + 1'b1;
      end
   end

   // Next-state decode; key edges take priority over a coincident threshold.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (press_edge) state_d = PRESS1;
         PRESS1: if (release_edge) state_d = DCLICK_EN ? WAIT2 : IDLE;
                 else if (thr_hit) state_d = LONG;
         WAIT2:  if (press_edge)   state_d = PRESS2;
                 else if (thr_hit) state_d = IDLE;
         PRESS2: if (release_edge) state_d = IDLE;
                 else if (thr_hit) state_d = LONG;
         LONG:   if (release_edge) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      timer_clr = (state_d != state_q) || (state_q == LONG && thr_hit);
   end

   // Event decode from current state, qualified edges and threshold.
   always_comb begin
      ev_short  = 1'b0;
      ev_dclick = 1'b0;
      ev_long   = 1'b0;
      ev_repeat = 1'b0;
      unique case (state_q)
         PRESS1: if (release_edge) ev_short = !DCLICK_EN;
                 else if (thr_hit) ev_long  = 1'b1;
         WAIT2:  if (!press_edge && thr_hit) ev_short = 1'b1;
         PRESS2: if (release_edge) ev_dclick = 1'b1;
                 else if (thr_hit) ev_long   = 1'b1;
         LONG:   if (!release_edge && thr_hit) ev_repeat = 1'b1;
         default: ;
      endcase
   end

   // Output register; busy tracks the state being entered so it aligns with state_q.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         short_press  <= 1'b0;
         double_click <= 1'b0;
         long_press   <= 1'b0;
         repeat_tick  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         short_press  <= ev_short;
         double_click <= ev_dclick;
         long_press   <= ev_long;
         repeat_tick  <= ev_repeat;
         busy         <= (state_d != IDLE);
      end
   end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Sits directly downstream of the key debouncer (`key_det`) and consumes its debounced level `key_state` and its one-cycle edge strobe `key_flag`.
- Classifies each debounced key gesture into one-cycle event pulses: short press, double click, long press, and auto-repeat while held.
- Feeds the application/control logic, which needs only single-cycle event strobes.
- Timing assumes a 50 MHz clk; all timing parameters are in clk cycles.

Parameters:
- LONG_CYCLES, 50_000_000, hold time that qualifies a long press (1 s).
- DCLICK_GAP, 15_000_000, maximum released gap that still counts as a double click (300 ms).
- REPEAT_CYCLES, 10_000_000, repeat-pulse period while a long press is held (200 ms).
- DCLICK_EN, 1, 1 = double-click detection on; 0 = short_press issued at release.
- CNT_W, 26, timer width; must hold max(LONG_CYCLES, DCLICK_GAP, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- key_state  input  1  debounced key level: 1 = released, 0 = pressed.
- key_flag  input  1  one-cycle strobe on each debounced edge.
- short_press  output  1  one-cycle pulse: single short press.
- double_click  output  1  one-cycle pulse: two short presses within DCLICK_GAP.
- long_press  output  1  one-cycle pulse: hold reached LONG_CYCLES.
- repeat_tick  output  1  one-cycle pulse every REPEAT_CYCLES while long-held.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Edge qualification:
  - press_edge = key_flag & ~key_state.
  - release_edge = key_flag & key_state.
  - key_flag without a state change relevant to the current FSM state is ignored.
- Reset (async, reset=0):
  - FSM → IDLE, timer → 0.
  - All outputs 0, including busy.
  - Reset mid-gesture discards that gesture; no pulse is issued.
- All outputs are registered. Every event output is exactly one cycle wide, and at most one event output is high in any cycle.
- Timer rule: the timer clears to 0 on every state transition and increments by 1 each cycle while the FSM stays in a timed state. A threshold N fires on the cycle the timer equals N-1; the registered pulse appears the following cycle.
- IDLE:
  - press_edge → PRESS1.
  - Any other input is ignored.
- PRESS1 (timed against LONG_CYCLES):
  - release_edge → WAIT2 if DCLICK_EN=1.
  - release_edge → IDLE with short_press if DCLICK_EN=0.
  - Threshold reached → long_press, then → LONG.
  - If release_edge and the threshold coincide, release wins: no long_press.
- WAIT2 (timed against DCLICK_GAP):
  - press_edge → PRESS2.
  - Threshold reached → short_press, then → IDLE.
  - If press_edge and the threshold coincide, the press wins and enters PRESS2.
- PRESS2 (timed against LONG_CYCLES):
  - release_edge → double_click, then → IDLE.
  - Threshold reached → long_press, then → LONG. The pending double click is dropped.
- LONG (timed against REPEAT_CYCLES):
  - On the threshold: repeat_tick, timer clears, stay in LONG.
  - release_edge → IDLE with no pulse; a release coinciding with the threshold suppresses repeat_tick.
- Latency, counted in clk edges from the edge that samples the qualifying flag:
  - short_press (DCLICK_EN=1): DCLICK_GAP+1 edges after the release.
  - short_press (DCLICK_EN=0): 1 edge after the release.
  - double_click: 1 edge after the second release.
  - long_press: LONG_CYCLES+1 edges after the press.
  - First repeat_tick: REPEAT_CYCLES edges after long_press; subsequent ticks every REPEAT_CYCLES.
- busy = (state != IDLE), registered.

Test Plan:
Bench overrides: LONG_CYCLES=100, DCLICK_GAP=40, REPEAT_CYCLES=20, DCLICK_EN=1; inputs driven as from the debouncer.
- Single click: press, release 30 cycles later, no further edges → exactly one short_press, 41 cycles after the release; no other pulses; busy low afterwards.
- Double click: press 10 cycles, release, press again 25 cycles later, release after 10 → one double_click 1 cycle after the second release; no short_press.
- Long hold: press and hold 170 cycles, then release → long_press at cycle 101; repeat_tick at 121, 141, 161; nothing after the release.
- Boundaries:
  - Release in PRESS1 on the exact LONG threshold cycle → no long_press; FSM enters WAIT2.
  - Second press on the exact WAIT2 threshold cycle → no short_press; the gesture completes as double_click.
- Robustness:
  - key_flag pulses with unchanged key_state in every state → ignored.
  - reset asserted mid-PRESS2 → all outputs 0 immediately (async); busy 0; no pulse after reset release.
- DCLICK_EN=0 rerun of the single-click case → short_press 1 cycle after the release; a fast second click yields a second short_press.
